pow_32: RTL and testbench
=========================

// Module: pow_32
// PURPOSE
//  Iterative unsigned exponentiator: y = x^e mod 2^32, computed by right-to-left
//  square-and-multiply, one exponent bit per clock. Standalone datapath block for the
//  modular-exponentiation subsystem; the host pulses ld, waits for done, then reads y.
//  Fixed, data-independent latency; no early termination on small exponents.
// PARAMETERS
//  W   32  operand/result width; the exponent is processed over exactly W iterations
// PORTS
//  clk   in   1   system clock; all state changes on the rising edge
//  rst   in   1   asynchronous reset, active-high
//  ld    in   1   start pulse; x and e are sampled on the rising edge where ld=1
//  x     in   W   base, unsigned
//  e     in   W   exponent, unsigned
//  y     out  W   result x^e mod 2^W; valid while done=1
//  done  out  1   high when the result is valid; low while busy or after reset
// BEHAVIOUR
//  - Registers: base[W], exp[W], acc[W], cnt[$clog2(W)+1], busy, done.
//  - Reset (async, rst=1): acc=1, base=0, exp=0, cnt=0, busy=0, done=0, so y=1.
//  - States: IDLE (busy=0, done=0), RUN (busy=1), DONE (busy=0, done=1).
//  - ld=1 on an edge, from any state including RUN: base<=x, exp<=e, acc<=1, cnt<=0,
//    busy<=1, done<=0. Any computation in progress is abandoned.
//  - RUN edge with ld=0:
//    - if exp[0] then acc<=acc*base, truncated to the low W bits;
//    - base<=base*base, truncated to the low W bits;
//    - exp<=exp>>1; cnt<=cnt+1.
//  - On the W-th RUN step (cnt==W-1): busy<=0, done<=1.
//  - Latency: done rises on the W-th (32nd) rising edge after the edge that sampled ld.
//    done is a clean 0->1 transition per operation and is usable as a completion event.
//  - DONE: y and done hold until the next ld or rst. x/e changes after sampling are ignored.
//  - y is driven directly from acc. Intermediate values are visible during RUN but are
//    valid only when done=1.
//  - Arithmetic: both multiplies are unsigned W x W keeping the low W bits. They may be
//    combinational; each product must settle within one cycle.
//  - Boundaries:
//    - e=0 gives y=1, for any x including x=0.
//    - x=0 with e>0 gives y=0.
//    - x=1 gives y=1.
//    - Overflow wraps modulo 2^W.
//  - rst mid-operation: immediate return to IDLE; done=0, y=1.
//  - ld held high for several cycles restarts on every edge. Computation begins from the
//    last edge with ld=1.
// TESTING
//  - Reset: rst=1 -> done=0, y=1. Release rst; done stays 0 with ld=0.
//  - ld pulse, x=3, e=5 -> done rises exactly 32 edges later, y=0x000000F3.
//  - x=0x0000FFFF, e=2 -> y=0xFFFE0001. x=0x00010000, e=2 -> y=0 (wrap).
//  - x=0xFFFFFFFF: e=0x10 -> y=1; e=0x11 -> y=0xFFFFFFFF. x=0, e=0 -> y=1.
//  - x=0x00ABCDEF, e=0x00654321 -> y equals a 32-bit software model of pow mod 2^32.
//    Also assert rst mid-run -> done=0, y=1.
//  - Issue ld at step 10 of a run with new x=7, e=4 -> done after 32 more edges, y=0x961.

Source files
------------

// File: rtl/pow_32.sv
// Iterative unsigned exponentiator, y = x^e mod 2^W.
// Right-to-left square-and-multiply, one exponent bit per clock.
module pow_32 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] x,
  input  logic [W-1:0] e,
  output logic [W-1:0] y,
  output logic         done
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_base;
  logic [W-1:0]  r_exp;
  logic [W-1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  w_sq;
  logic [W-1:0]  w_mul;
  logic          w_run;

  assign w_run = (r_state == S_RUN);
  assign w_sq  = r_base * r_base;
  assign w_mul = r_acc * r_base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (ld) begin
      w_next = S_RUN;
    end else begin
      unique case (r_state)
        S_RUN:   if (r_cnt == LAST) w_next = S_DONE;
        S_DONE:  w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // ld has priority, so a new operation abandons any run in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base <= '0;
      r_exp  <= '0;
      r_acc  <= W'(1);
      r_cnt  <= '0;
    end else if (ld) begin
      r_base <= x;
      r_exp  <= e;
      r_acc  <= W'(1);
      r_cnt  <= '0;
    end else if (w_run) begin
      if (r_exp[0]) r_acc <= w_mul;
      r_base <= w_sq;
      r_exp  <= r_exp >> 1;
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign y    = r_acc;
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_pow_32.sv
// Directed self-checking bench for pow_32.
// Checks results, exact latency, reset, restart and hold behaviour.
module tb_pow_32;

  logic        clk;
  logic        rst;
  logic        ld;
  logic [31:0] x;
  logic [31:0] e;
  logic [31:0] y;
  logic        done;

  int n_chk;
  int n_err;
  int lat;

  pow_32 dut (
    .clk  (clk),
    .rst  (rst),
    .ld   (ld),
    .x    (x),
    .e    (e),
    .y    (y),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // left-to-right method, independent of the DUT's bit order
  function automatic logic [31:0] pow_ref(input logic [31:0] b,
                                          input logic [31:0] ex);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 31; i >= 0; i--) begin
      r = r * r;
      if (ex[i]) r = r * b;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] xv, input logic [31:0] ev);
    ld = 1'b1;
    x  = xv;
    e  = ev;
    step();
    ld = 1'b0;
    x  = $urandom;
    e  = $urandom;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] xv,
                     input logic [31:0] ev, input logic [31:0] exp);
    int n;
    start(xv, ev);
    chk({tag, "_busy"}, {31'd0, done}, 32'd0);
    wait_done(n);
    chk({tag, "_lat"}, n, 32'd32);
    chk({tag, "_y"}, y, exp);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    ld  = 1'b0;
    x   = '0;
    e   = '0;
    #12;
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_y", y, 32'd1);
    rst = 1'b0;
    repeat (3) step();
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_y", y, 32'd1);

    run("p3_5", 32'd3, 32'd5, 32'h0000_00F3);
    repeat (4) step();
    chk("hold_done", {31'd0, done}, 32'd1);
    chk("hold_y", y, 32'h0000_00F3);

    run("ffff_sq", 32'h0000_FFFF, 32'd2, 32'hFFFE_0001);
    run("wrap", 32'h0001_0000, 32'd2, 32'h0000_0000);
    run("m1_e16", 32'hFFFF_FFFF, 32'h10, 32'h0000_0001);
    run("m1_e17", 32'hFFFF_FFFF, 32'h11, 32'hFFFF_FFFF);
    run("zero_zero", 32'd0, 32'd0, 32'd1);
    run("zero_pos", 32'd0, 32'd9, 32'd0);
    run("one", 32'd1, 32'hDEAD_BEEF, 32'd1);
    run("big", 32'h00AB_CDEF, 32'h0065_4321,
        pow_ref(32'h00AB_CDEF, 32'h0065_4321));
    run("rnd", 32'h1234_5679, 32'h8765_4321,
        pow_ref(32'h1234_5679, 32'h8765_4321));

    // asynchronous reset in the middle of a run
    start(32'd5, 32'd13);
    repeat (5) step();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_y", y, 32'd1);
    #3;
    rst = 1'b0;
    repeat (40) step();
    chk("post_rst_idle", {31'd0, done}, 32'd0);

    // restart at step 10 of a run
    start(32'd3, 32'd5);
    repeat (9) step();
    chk("restart_pre", {31'd0, done}, 32'd0);
    run("restart", 32'd7, 32'd4, 32'h0000_0961);

    // ld held across several edges: last edge wins
    ld = 1'b1;
    x  = 32'd9;
    e  = 32'd9;
    step();
    step();
    x = 32'd2;
    e = 32'd10;
    step();
    ld = 1'b0;
    wait_done(lat);
    chk("hold_ld_lat", lat, 32'd32);
    chk("hold_ld_y", y, 32'd1024);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
